// File: rtl/if_id_stage.sv
// MIPS fetch stage and IF/ID pipeline register: PC, next-PC select, fetched-word latch.
// Define BRANCH_DELAY_SLOT_EN to let the delay-slot instruction through on a redirect.
module if_id_stage #(
  parameter int                     PC_WIDTH    = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     IMM_WIDTH   = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  input  logic                   jump,
  input  logic [25:0]            jumpIndex,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [INSTR_WIDTH-1:0] instr_id,
  output logic [PC_WIDTH-1:0]    pcPlus4_id,
  output logic                   valid_id,
  output logic [IMM_WIDTH-1:0]   immediate_id,
  output logic [4:0]             rs_id,
  output logic [4:0]             rt_id,
  output logic [4:0]             rd_id
);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcPlus4_q, pcPlus4_d;
  logic                   valid_q, valid_d;

  logic [PC_WIDTH-1:0]    pcPlus4;
  logic                   redirect;
  logic                   squash;
  logic                   unusedTargetLsbs;

  assign pcPlus4          = pc_q + PC_WIDTH'(4);
  assign redirect         = branchTaken | jump;
  assign unusedTargetLsbs = ^branchTarget[1:0];

`ifdef BRANCH_DELAY_SLOT_EN
  assign squash = flush;
`else
  assign squash = flush | redirect;
`endif

  // A redirect beats stall: whatever ID is holding is already wrong-path.
  always_comb begin
    pc_d = pcPlus4;
    if (branchTaken) begin
      pc_d = {branchTarget[PC_WIDTH-1:2], 2'b00};
    end else if (jump) begin
      pc_d = {pcPlus4[PC_WIDTH-1:28], jumpIndex, 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_comb begin
    instr_d   = instr_q;
    pcPlus4_d = pcPlus4_q;
    valid_d   = valid_q;
    if (squash) begin
      instr_d   = '0;
      pcPlus4_d = '0;
      valid_d   = 1'b0;
    end else if (!stall) begin
      instr_d   = imemData;
      pcPlus4_d = pcPlus4;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      pcPlus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pcPlus4_q <= pcPlus4_d;
      valid_q   <= valid_d;
    end
  end

  assign imemAddr     = pc_q;
  assign instr_id     = instr_q;
  assign pcPlus4_id   = pcPlus4_q;
  assign valid_id     = valid_q;
  assign immediate_id = instr_q[IMM_WIDTH-1:0];
  assign rs_id        = instr_q[25:21];
  assign rt_id        = instr_q[20:16];
  assign rd_id        = instr_q[15:11];

endmodule

// File: tb/tb_if_id_stage.sv
// Testbench for if_id_stage: directed vector table, multi-cycle corner sequences,
// a wrapping-reset instance, and randomized traffic against a behavioural model.
module tb_if_id_stage;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, branchTaken, jump;
  logic [31:0] branchTarget;
  logic [25:0] jumpIndex;

  logic [31:0] imemAddr, imemData, instr_id, pcPlus4_id;
  logic        valid_id;
  logic [15:0] immediate_id;
  logic [4:0]  rs_id, rt_id, rd_id;

  logic [31:0] imemAddr2, imemData2, instr_id2, pcPlus4_id2;
  logic        valid_id2;
  logic [15:0] immediate_id2;
  logic [4:0]  rs_id2, rt_id2, rd_id2;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct pseudo-random word per address.
  function automatic logic [31:0] imemWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  assign imemData  = imemWord(imemAddr);
  assign imemData2 = imemWord(imemAddr2);

  if_id_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpIndex(jumpIndex),
    .imemAddr(imemAddr), .imemData(imemData),
    .instr_id(instr_id), .pcPlus4_id(pcPlus4_id), .valid_id(valid_id),
    .immediate_id(immediate_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpIndex(jumpIndex),
    .imemAddr(imemAddr2), .imemData(imemData2),
    .instr_id(instr_id2), .pcPlus4_id(pcPlus4_id2), .valid_id(valid_id2),
    .immediate_id(immediate_id2), .rs_id(rs_id2), .rt_id(rt_id2), .rd_id(rd_id2)
  );

  typedef struct {
    logic        rstN;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] brTarget;
    logic        jump;
    logic [25:0] jIdx;
    logic [31:0] expPc;
    logic        expValid;
    logic [31:0] expInstrPc;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic rstN, input logic st, input logic fl,
                              input logic br, input logic [31:0] tgt,
                              input logic jp, input logic [25:0] idx,
                              input logic [31:0] ePc, input logic eValid,
                              input logic [31:0] eInstrPc);
    vec_t v;
    v.rstN = rstN; v.stall = st; v.flush = fl; v.br = br; v.brTarget = tgt;
    v.jump = jp; v.jIdx = idx; v.expPc = ePc; v.expValid = eValid;
    v.expInstrPc = eInstrPc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Compares every main-DUT output against an expected PC and IF/ID contents.
  task automatic checkAll(input string tag, input logic [31:0] ePc,
                          input logic eValid, input logic [31:0] eInstr,
                          input logic [31:0] ePc4);
    checkOutput({tag, " imemAddr"}, imemAddr, ePc);
    checkOutput({tag, " valid_id"}, {31'd0, valid_id}, {31'd0, eValid});
    checkOutput({tag, " instr_id"}, instr_id, eInstr);
    checkOutput({tag, " pcPlus4_id"}, pcPlus4_id, ePc4);
    checkOutput({tag, " fields"},
                {1'b0, rs_id, rt_id, rd_id, immediate_id},
                {1'b0, eInstr[25:21], eInstr[20:16], eInstr[15:11], eInstr[15:0]});
  endtask

  task automatic applyStimulus(input logic rstN, input logic st, input logic fl,
                               input logic br, input logic [31:0] tgt,
                               input logic jp, input logic [25:0] idx);
    rst_n = rstN; stall = st; flush = fl; branchTaken = br;
    branchTarget = tgt; jump = jp; jumpIndex = idx;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mPc, mInstr, mPc4, p4, nPc;
  logic        mValid, rRst, rSt, rFl, rBr, rJp, squash;
  logic [31:0] rTgt;
  logic [25:0] rIdx;

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branchTaken = 1'b0;
    branchTarget = '0; jump = 1'b0; jumpIndex = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 32'h0, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap reset imemAddr", imemAddr2, 32'hFFFF_FFFC);
    checkOutput("wrap reset valid", {31'd0, valid_id2}, 32'd0);

    vecs[0]  = mk(1,0,0,0,0,0,0, 32'h4,  1, 32'h0);
    vecs[1]  = mk(1,0,0,0,0,0,0, 32'h8,  1, 32'h4);
    vecs[2]  = mk(1,0,0,0,0,0,0, 32'hC,  1, 32'h8);
    vecs[3]  = mk(1,0,0,0,0,0,0, 32'h10, 1, 32'hC);
    vecs[4]  = mk(1,1,0,0,0,0,0, 32'h10, 1, 32'hC);
    vecs[5]  = mk(1,1,0,0,0,0,0, 32'h10, 1, 32'hC);
    vecs[6]  = mk(1,1,0,0,0,0,0, 32'h10, 1, 32'hC);
    vecs[7]  = mk(1,0,0,0,0,0,0, 32'h14, 1, 32'h10);
    vecs[8]  = mk(1,0,0,0,0,0,0, 32'h18, 1, 32'h14);
    vecs[9]  = mk(1,0,0,0,0,0,0, 32'h1C, 1, 32'h18);
    vecs[10] = mk(1,0,0,0,0,0,0, 32'h20, 1, 32'h1C);
    vecs[11] = mk(1,0,0,1,32'h103,0,0, 32'h100, DS, 32'h20);
    vecs[12] = mk(1,0,0,0,0,0,0, 32'h104, 1, 32'h100);
    vecs[13] = mk(1,0,0,0,0,1,26'h40, 32'h100, DS, 32'h104);
    vecs[14] = mk(1,0,0,1,32'h4000_0011,0,0, 32'h4000_0010, DS, 32'h100);
    vecs[15] = mk(1,0,0,0,0,1,26'h40, 32'h4000_0100, DS, 32'h4000_0010);
    vecs[16] = mk(1,1,1,1,32'h200,0,0, 32'h200, 0, 32'h0);
    vecs[17] = mk(1,0,1,0,0,0,0, 32'h204, 0, 32'h0);
    vecs[18] = mk(1,1,1,0,0,0,0, 32'h204, 0, 32'h0);
    vecs[19] = mk(1,0,0,0,0,0,0, 32'h208, 1, 32'h204);
    vecs[20] = mk(1,1,0,0,0,1,26'h3FF_FFFF, 32'h0FFF_FFFC, DS, 32'h204);
    vecs[21] = mk(1,0,0,0,0,0,0, 32'h1000_0000, 1, 32'h0FFF_FFFC);
    vecs[22] = mk(0,1,0,1,32'h300,0,0, 32'h0, 0, 32'h0);
    vecs[23] = mk(1,0,0,0,0,0,0, 32'h4, 1, 32'h0);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rstN, vecs[i].stall, vecs[i].flush, vecs[i].br,
                    vecs[i].brTarget, vecs[i].jump, vecs[i].jIdx);
      checkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expValid,
               vecs[i].expValid ? imemWord(vecs[i].expInstrPc) : 32'h0,
               vecs[i].expValid ? vecs[i].expInstrPc + 32'd4 : 32'h0);
      if (i == 0) begin
        checkOutput("wrap imemAddr", imemAddr2, 32'h0);
        checkOutput("wrap pcPlus4_id", pcPlus4_id2, 32'h0);
        checkOutput("wrap valid_id", {31'd0, valid_id2}, 32'd1);
        checkOutput("wrap instr_id", instr_id2, imemWord(32'hFFFF_FFFC));
      end
    end

    mPc = 32'h4; mInstr = imemWord(32'h0); mPc4 = 32'h4; mValid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rRst = ($urandom_range(0, 39) != 0);
      rSt  = ($urandom_range(0, 3) == 0);
      rFl  = ($urandom_range(0, 7) == 0);
      rBr  = ($urandom_range(0, 7) == 0);
      rJp  = ($urandom_range(0, 7) == 0);
      rTgt = $urandom;
      rIdx = 26'($urandom);
      applyStimulus(rRst, rSt, rFl, rBr, rTgt, rJp, rIdx);
      if (!rRst) begin
        mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
      end else begin
        p4 = mPc + 32'd4;
        if (rBr)       nPc = rTgt & ~32'h3;
        else if (rJp)  nPc = (p4 & 32'hF000_0000) | ({6'd0, rIdx} << 2);
        else if (rSt)  nPc = mPc;
        else           nPc = p4;
        squash = rFl || (!DS && (rBr || rJp));
        if (squash) begin
          mInstr = 32'h0; mPc4 = 32'h0; mValid = 1'b0;
        end else if (!rSt) begin
          mInstr = imemWord(mPc); mPc4 = p4; mValid = 1'b1;
        end
        mPc = nPc;
      end
      checkAll($sformatf("rand%0d", c), mPc, mValid, mInstr, mPc4);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
